// File: rtl/mips_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_multi_pkg
// Summary  : Shared encodings for the multicycle MIPS control path.
// Revision : 1.0 - initial release
// ============================================================================
package mips_multi_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;

  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_sub = 3'b110;
  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_slt = 3'b111;

  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  localparam logic [1:0] c_srcb_b      = 2'b00;
  localparam logic [1:0] c_srcb_four   = 2'b01;
  localparam logic [1:0] c_srcb_imm    = 2'b10;
  localparam logic [1:0] c_srcb_imm_sh = 2'b11;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      c_op_rtype, c_op_lw, c_op_sw, c_op_beq, c_op_addi, c_op_j: return 1'b1;
      default:                                                   return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multi_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_decoder
// Summary  : Maps ALU operation class and Funct field to ALU_control.
// Revision : 1.0 - initial release
// ============================================================================
module mips_alu_decoder
  import mips_multi_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] Funct,
  output logic [2:0] ALU_control,
  output logic       funct_illegal
);

  always_comb begin
    ALU_control   = c_alu_add;
    funct_illegal = 1'b0;
    case (alu_op)
      c_aluop_sub: ALU_control = c_alu_sub;
      c_aluop_funct: begin
        case (Funct)
          c_fn_add: ALU_control = c_alu_add;
          c_fn_sub: ALU_control = c_alu_sub;
          c_fn_and: ALU_control = c_alu_and;
          c_fn_or:  ALU_control = c_alu_or;
          c_fn_slt: ALU_control = c_alu_slt;
          default:  funct_illegal = 1'b1;
        endcase
      end
      default: ALU_control = c_alu_add;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multi_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multi_control
// Summary  : Moore control FSM for a multicycle MIPS datapath.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multi_control
  import mips_multi_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output logic       PC_write,
  output logic       Mem_write,
  output logic       lorD_mux,
  output logic       IR_write,
  output logic       Reg_Dst_mux,
  output logic       Mem_reg_mux,
  output logic       Reg_write,
  output logic       ALU_srcA_mux,
  output logic       Branch,
  output logic       ALU_reg_write,
  output logic [1:0] ALU_srcB_mux,
  output logic [2:0] ALU_control,
  output logic [1:0] Pc_src_mux,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  localparam state_t c_illegal_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_mem_is_load;
  logic [1:0] w_alu_op;
  logic       w_funct_illegal;

  mips_alu_decoder u_alu_decoder (
    .alu_op        (w_alu_op),
    .Funct         (Funct),
    .ALU_control   (ALU_control),
    .funct_illegal (w_funct_illegal)
  );

  // Load/store flavour is captured in DECODE so Op may change afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_mem_is_load <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_mem_is_load <= (Op == c_op_lw);
      end
    end
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          c_op_lw, c_op_sw: w_next_state = S_MEMADR;
          c_op_rtype:       w_next_state = S_EXECUTE;
          c_op_beq:         w_next_state = S_BRANCH;
          c_op_addi:        w_next_state = S_ADDIEX;
          c_op_j:           w_next_state = S_JUMP;
          default:          w_next_state = c_illegal_next;
        endcase
      end
      S_MEMADR:  w_next_state = r_mem_is_load ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next_state = S_MEMWB;
      S_EXECUTE: w_next_state = w_funct_illegal ? c_illegal_next : S_ALUWB;
      S_ADDIEX:  w_next_state = S_ADDIWB;
      S_HALT:    w_next_state = S_HALT;
      default:   w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    PC_write      = 1'b0;
    Mem_write     = 1'b0;
    lorD_mux      = 1'b0;
    IR_write      = 1'b0;
    Reg_Dst_mux   = 1'b0;
    Mem_reg_mux   = 1'b0;
    Reg_write     = 1'b0;
    ALU_srcA_mux  = 1'b0;
    Branch        = 1'b0;
    ALU_reg_write = 1'b0;
    ALU_srcB_mux  = c_srcb_b;
    Pc_src_mux    = c_pcsrc_alu;
    w_alu_op      = c_aluop_add;
    illegal_o     = 1'b0;
    case (r_state)
      S_FETCH: begin
        IR_write     = 1'b1;
        PC_write     = 1'b1;
        ALU_srcB_mux = c_srcb_four;
      end
      S_DECODE: begin
        ALU_srcB_mux  = c_srcb_imm_sh;
        ALU_reg_write = 1'b1;
        illegal_o     = !op_supported(Op);
      end
      S_MEMADR, S_ADDIEX: begin
        ALU_srcA_mux  = 1'b1;
        ALU_srcB_mux  = c_srcb_imm;
        ALU_reg_write = 1'b1;
      end
      S_MEMRD: lorD_mux = 1'b1;
      S_MEMWB: begin
        Reg_write   = 1'b1;
        Mem_reg_mux = 1'b1;
      end
      S_MEMWR: begin
        lorD_mux  = 1'b1;
        Mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ALU_srcA_mux  = 1'b1;
        w_alu_op      = c_aluop_funct;
        ALU_reg_write = 1'b1;
        illegal_o     = w_funct_illegal;
      end
      S_ALUWB: begin
        Reg_write   = 1'b1;
        Reg_Dst_mux = 1'b1;
      end
      S_BRANCH: begin
        ALU_srcA_mux = 1'b1;
        w_alu_op     = c_aluop_sub;
        Branch       = 1'b1;
        Pc_src_mux   = c_pcsrc_aluout;
      end
      S_ADDIWB: Reg_write = 1'b1;
      S_JUMP: begin
        PC_write   = 1'b1;
        Pc_src_mux = c_pcsrc_jump;
      end
      default: ;
    endcase
  end

  assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multi_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multi_control
// Summary  : Instruction-level checker for mips_multi_control (trap on/off).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multi_control;

  localparam logic [3:0] c_st_fetch   = 4'd0;
  localparam logic [3:0] c_st_decode  = 4'd1;
  localparam logic [3:0] c_st_memadr  = 4'd2;
  localparam logic [3:0] c_st_memrd   = 4'd3;
  localparam logic [3:0] c_st_memwb   = 4'd4;
  localparam logic [3:0] c_st_memwr   = 4'd5;
  localparam logic [3:0] c_st_execute = 4'd6;
  localparam logic [3:0] c_st_aluwb   = 4'd7;
  localparam logic [3:0] c_st_branch  = 4'd8;
  localparam logic [3:0] c_st_addiex  = 4'd9;
  localparam logic [3:0] c_st_addiwb  = 4'd10;
  localparam logic [3:0] c_st_jump    = 4'd11;
  localparam logic [3:0] c_st_halt    = 4'd12;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, mem_write, lord, ir_write, reg_dst, mem_reg;
    logic       reg_write, srca, branch, alu_reg_write;
    logic [1:0] srcb;
    logic [2:0] aluctl;
    logic [1:0] pcsrc;
    logic       illegal;
  } outv_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;

  logic       pcw0, mw0, lord0, irw0, rd0, mr0, rw0, sa0, br0, arw0, ill0;
  logic [1:0] sb0, ps0;
  logic [2:0] ac0;
  logic [3:0] st0;
  logic       pcw1, mw1, lord1, irw1, rd1, mr1, rw1, sa1, br1, arw1, ill1;
  logic [1:0] sb1, ps1;
  logic [2:0] ac1;
  logic [3:0] st1;
  outv_t      obs0, obs1;

  int         n_vec = 0;
  int         n_err = 0;
  logic       halted = 1'b0;
  logic [3:0] path_q[$];

  always #5 clk = ~clk;

  mips_multi_control #(.ILLEGAL_TRAP(1'b0)) u_dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .PC_write(pcw0), .Mem_write(mw0), .lorD_mux(lord0), .IR_write(irw0),
    .Reg_Dst_mux(rd0), .Mem_reg_mux(mr0), .Reg_write(rw0), .ALU_srcA_mux(sa0),
    .Branch(br0), .ALU_reg_write(arw0), .ALU_srcB_mux(sb0), .ALU_control(ac0),
    .Pc_src_mux(ps0), .state_o(st0), .illegal_o(ill0)
  );

  mips_multi_control #(.ILLEGAL_TRAP(1'b1)) u_trap (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .PC_write(pcw1), .Mem_write(mw1), .lorD_mux(lord1), .IR_write(irw1),
    .Reg_Dst_mux(rd1), .Mem_reg_mux(mr1), .Reg_write(rw1), .ALU_srcA_mux(sa1),
    .Branch(br1), .ALU_reg_write(arw1), .ALU_srcB_mux(sb1), .ALU_control(ac1),
    .Pc_src_mux(ps1), .state_o(st1), .illegal_o(ill1)
  );

  always_comb begin
    obs0 = {st0, pcw0, mw0, lord0, irw0, rd0, mr0, rw0, sa0, br0, arw0, sb0, ac0, ps0, ill0};
    obs1 = {st1, pcw1, mw1, lord1, irw1, rd1, mr1, rw1, sa1, br1, arw1, sb1, ac1, ps1, ill1};
  end

  function automatic logic op_ok(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Returns {legal, alu_control} for an R-type Funct.
  function automatic logic [3:0] fn_info(input logic [5:0] fn);
    case (fn)
      6'b100000: return {1'b1, 3'b010};
      6'b100010: return {1'b1, 3'b110};
      6'b100100: return {1'b1, 3'b000};
      6'b100101: return {1'b1, 3'b001};
      6'b101010: return {1'b1, 3'b111};
      default:   return {1'b0, 3'b010};
    endcase
  endfunction

  function automatic outv_t exp_of(input logic [3:0] s, input logic [5:0] op,
                                   input logic [5:0] fn);
    outv_t      e;
    logic [3:0] fi;
    e        = '0;
    e.st     = s;
    e.aluctl = 3'b010;
    fi       = fn_info(fn);
    case (s)
      c_st_fetch:   begin e.ir_write = 1; e.pc_write = 1; e.srcb = 2'b01; end
      c_st_decode:  begin e.srcb = 2'b11; e.alu_reg_write = 1; e.illegal = !op_ok(op); end
      c_st_memadr:  begin e.srca = 1; e.srcb = 2'b10; e.alu_reg_write = 1; end
      c_st_memrd:   e.lord = 1;
      c_st_memwb:   begin e.reg_write = 1; e.mem_reg = 1; end
      c_st_memwr:   begin e.lord = 1; e.mem_write = 1; end
      c_st_execute: begin
        e.srca = 1; e.aluctl = fi[2:0]; e.alu_reg_write = 1; e.illegal = !fi[3];
      end
      c_st_aluwb:   begin e.reg_write = 1; e.reg_dst = 1; end
      c_st_branch:  begin e.srca = 1; e.aluctl = 3'b110; e.branch = 1; e.pcsrc = 2'b01; end
      c_st_addiex:  begin e.srca = 1; e.srcb = 2'b10; e.alu_reg_write = 1; end
      c_st_addiwb:  e.reg_write = 1;
      c_st_jump:    begin e.pc_write = 1; e.pcsrc = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  // State sequence an instruction walks through with the trap disabled.
  task automatic build_path(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] fi;
    fi = fn_info(fn);
    path_q = {c_st_fetch, c_st_decode};
    case (op)
      6'b100011: path_q = {path_q, c_st_memadr, c_st_memrd, c_st_memwb};
      6'b101011: path_q = {path_q, c_st_memadr, c_st_memwr};
      6'b000000: begin
        path_q.push_back(c_st_execute);
        if (fi[3]) path_q.push_back(c_st_aluwb);
      end
      6'b000100: path_q.push_back(c_st_branch);
      6'b001000: path_q = {path_q, c_st_addiex, c_st_addiwb};
      6'b000010: path_q.push_back(c_st_jump);
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input outv_t obs, input outv_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each step starts in the clock-low phase and ends at the next falling edge.
  task automatic run_instr(input string tag, input logic [5:0] op,
                           input logic [5:0] fn, input int max_steps);
    outv_t e, e1;
    build_path(op, fn);
    for (int k = 0; k < path_q.size() && k < max_steps; k++) begin
      if (path_q[k] == c_st_decode || path_q[k] == c_st_execute) begin
        Op    = op;
        Funct = fn;
      end else begin
        Op    = 6'($urandom);
        Funct = 6'($urandom);
      end
      #1;
      e  = exp_of(path_q[k], op, fn);
      e1 = halted ? exp_of(c_st_halt, op, fn) : e;
      check(tag, obs0, e);
      check({tag, "_trap"}, obs1, e1);
      if (e.illegal) halted = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    Op    = 6'h3f;
    #1;
    check("reset", obs0, exp_of(c_st_fetch, 6'h3f, 6'h3f));
    check("reset_trap", obs1, exp_of(c_st_fetch, 6'h3f, 6'h3f));
    repeat (2) @(negedge clk);
    #1;
    check("reset_held", obs0, exp_of(c_st_fetch, 6'h3f, 6'h3f));
    check("reset_held_trap", obs1, exp_of(c_st_fetch, 6'h3f, 6'h3f));
    #1 reset = 1'b0;
    halted = 1'b0;
  endtask

  task automatic run_random(input int n);
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int i = 0; i < n; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr("random", op, fn, 99);
    end
  endtask

  initial begin
    do_reset();
    run_instr("lw", 6'b100011, 6'b000000, 99);
    run_instr("rtype_slt", 6'b000000, 6'b101010, 99);
    run_instr("beq", 6'b000100, 6'b000000, 99);
    run_instr("sw", 6'b101011, 6'b000000, 99);
    run_instr("j", 6'b000010, 6'b000000, 99);
    run_instr("addi", 6'b001000, 6'b000000, 99);
    run_instr("rtype_and", 6'b000000, 6'b100100, 99);
    run_instr("rtype_or", 6'b000000, 6'b100101, 99);
    run_instr("rtype_sub", 6'b000000, 6'b100010, 99);

    // Illegal Op: untrapped copy refetches, trapped copy parks in HALT.
    run_instr("illegal_op", 6'b111111, 6'b100000, 99);
    run_instr("illegal_funct", 6'b000000, 6'b111111, 99);
    for (int i = 0; i < 6; i++) run_instr("after_halt", 6'b100011, 6'b000000, 99);
    do_reset();

    run_instr("illegal_funct_trap", 6'b000000, 6'b000001, 99);
    run_instr("halted_addi", 6'b001000, 6'b000000, 99);
    do_reset();

    // Async reset in the middle of a store's MEMWR cycle.
    run_instr("sw_part", 6'b101011, 6'b000000, 3);
    Op = 6'($urandom);
    #1;
    check("memwr", obs0, exp_of(c_st_memwr, 6'b101011, 6'b0));
    #2 reset = 1'b1;
    #1;
    check("async_reset", obs0, exp_of(c_st_fetch, 6'b101011, 6'b0));
    check("async_reset_trap", obs1, exp_of(c_st_fetch, 6'b101011, 6'b0));
    @(negedge clk);
    #1 reset = 1'b0;
    halted = 1'b0;
    run_instr("post_reset_lw", 6'b100011, 6'b000000, 99);

    for (int r = 0; r < 4; r++) begin
      run_random(12);
      do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
